shift_out_lanes: RTL
====================

SHIFT_OUT_LANES -- requirements
Module: shift_out_lanes

Interface
REQ-001 SHALL have parameter WIDTH, default 84, total frame bits (7 x 12 seven-segment digits).
REQ-002 SHALL have parameter LANES, default 1, number of parallel serial data lines.
REQ-003 SHALL have parameter CLK_DIV, default 1, sclk half-period in clk cycles.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = highest bit of each lane slice first, 0 = lowest first.
REQ-005 SHALL have parameter LATCH_CYCLES, default 1, latch pulse width in clk cycles.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port start_i, input, 1, frame request, sampled every cycle.
REQ-009 SHALL have port data_i, input, WIDTH, frame data, sampled only when a request is accepted.
REQ-010 SHALL have port sclk_o, output, 1, shift clock; external registers sample on its rising edge.
REQ-011 SHALL have port data_o, output, LANES, serial data, one bit per lane.
REQ-012 SHALL have port latch_o, output, 1, storage-register latch strobe.
REQ-013 SHALL have port busy_o, output, 1, high while a frame is in progress.
REQ-014 SHALL have port done_o, output, 1, one-cycle frame-complete pulse.

Function
REQ-015 SHALL fail elaboration if WIDTH % LANES != 0, CLK_DIV < 1 or LATCH_CYCLES < 1; N = WIDTH/LANES bits per lane.
REQ-016 SHALL drive data_o[k] from slice data[(k+1)*N-1 : k*N] of the captured frame.
REQ-017 SHALL implement states IDLE, SHIFT, LATCH, DONE.
REQ-018 IDLE: start_i=1 at edge t captures data_i into the shift buffer and enters SHIFT; busy_o=1 from t+1.
REQ-019 SHIFT, bit i (0..N-1): data_o valid from cycle t+1+2*CLK_DIV*i; sclk_o low CLK_DIV cycles, then high CLK_DIV cycles; data_o stable while sclk_o is high.
REQ-020 SHIFT -> LATCH after the high phase of bit N-1; sclk_o=0 and data_o holds its last value during LATCH.
REQ-021 LATCH: latch_o=1 for exactly LATCH_CYCLES cycles, then DONE.
REQ-022 DONE: exactly one cycle; done_o=1, busy_o=1, latch_o=0; then IDLE, or SHIFT when a request is pending.
REQ-023 Busy duration per frame SHALL be exactly 2*CLK_DIV*N + LATCH_CYCLES + 1 cycles.
REQ-024 start_i=1 in SHIFT, LATCH or DONE SHALL set a pending flag and capture data_i into a pending buffer; last request wins; the running frame is unaffected.
REQ-025 On DONE exit with pending set: load the pending buffer, clear pending, enter SHIFT; busy_o stays 1 with no IDLE gap.
REQ-026 start_i in IDLE SHALL never set pending.
REQ-027 In IDLE: sclk_o=0, latch_o=0, done_o=0, busy_o=0, data_o=0.
REQ-028 The bit counter SHALL be ceil(log2(N+1)) bits wide; the divider counter ceil(log2(CLK_DIV+1)) bits; neither counter wraps within a frame.
REQ-029 All outputs SHALL be driven directly from registers (glitch-free).

Reset
REQ-030 rst_i=1 SHALL immediately force IDLE, clear the pending flag, both buffers and all counters, and drive sclk_o, data_o, latch_o, busy_o and done_o to 0.
REQ-031 Reset mid-frame SHALL abort the frame with no latch pulse; the first start_i after rst_i falls begins a fresh frame per REQ-018.

Verification
REQ-032 WIDTH=8, LANES=1, CLK_DIV=1, MSB_FIRST=1, start with data 0xA5 -> 8 sclk rises sample 1,0,1,0,0,1,0,1; latch_o high at t+17; done_o at t+18; busy_o high 18 cycles.
REQ-033 WIDTH=8, LANES=2, MSB_FIRST=0, data 0x3C -> 4 sclk rises; lane0 samples 0,0,1,1; lane1 samples 1,1,0,0.
REQ-034 WIDTH=8, LANES=1, start 0x11, then 0x22 at bit 3, then 0x33 during LATCH -> frame 0x11 completes; next frame sends 0x33 only, starting the cycle after done_o with no IDLE gap.
REQ-035 CLK_DIV=3, LATCH_CYCLES=2, WIDTH=4 -> sclk high/low 3 cycles each; latch_o 2 cycles; busy_o 27 cycles.
REQ-036 Assert rst_i during bit 5 of 0xFF -> all outputs 0 on the same edge; no latch pulse; a start after release sends a complete fresh frame.
REQ-037 WIDTH=84, LANES=4 elaborates (N=21); WIDTH=84, LANES=5 fails elaboration.

Source files
------------

// File: rtl/shift_out_lanes.sv
// Multi-lane serial frame shifter for chained shift registers.
// Shifts a captured frame out on LANES data lines, then pulses a latch strobe.
module shift_out_lanes #(
    parameter int WIDTH        = 84,
    parameter int LANES        = 1,
    parameter int CLK_DIV      = 1,
    parameter int MSB_FIRST    = 1,
    parameter int LATCH_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             sclk_o,
    output logic [LANES-1:0] data_o,
    output logic             latch_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int N  = WIDTH / LANES;
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LAT_END  = LW'(LATCH_CYCLES - 1);

    if ((WIDTH % LANES) != 0 || CLK_DIV < 1 || LATCH_CYCLES < 1) begin : g_param_err
        $error("shift_out_lanes: illegal WIDTH/LANES/CLK_DIV/LATCH_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    // Bit b of every lane slice, in the configured shift order.
    function automatic logic [LANES-1:0] pick(input logic [WIDTH-1:0] f,
                                              input logic [BW-1:0]    b);
        int idx;
        pick = '0;
        idx  = (MSB_FIRST != 0) ? (N - 1 - int'(b)) : int'(b);
        for (int k = 0; k < LANES; k++) begin
            pick[k] = f[k*N + idx];
        end
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]   pbuf_q, pbuf_d;
    logic               pend_q, pend_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [DW-1:0]      div_q, div_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic               sclk_q, sclk_d;
    logic [LANES-1:0]   data_q, data_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   frame;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pbuf_d  = pbuf_q;
        pend_d  = pend_q;
        bit_d   = bit_q;
        div_d   = div_q;
        lat_d   = lat_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        frame   = start_i ? data_i : pbuf_q;

        if (start_i && (state_q == SHIFT || state_q == LATCH)) begin
            pend_d = 1'b1;
            pbuf_d = data_i;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    buf_d   = data_i;
                    bit_d   = '0;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    data_d  = pick(data_i, '0);
                end
            end
            SHIFT: begin
                if (div_q == DIV_END) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = LATCH;
                            latch_d = 1'b1;
                            lat_d   = '0;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            data_d = pick(buf_q, bit_q + 1'b1);
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (lat_q == LAT_END) begin
                    state_d = DONE;
                    latch_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DONE: begin
                // A request arriving in DONE itself wins over an older pending one.
                pend_d = 1'b0;
                if (start_i || pend_q) begin
                    state_d = SHIFT;
                    buf_d   = frame;
                    bit_d   = '0;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    data_d  = pick(frame, '0);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    data_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pbuf_q  <= '0;
            pend_q  <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
            lat_q   <= '0;
            sclk_q  <= 1'b0;
            data_q  <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk_o  = sclk_q;
    assign data_o  = data_q;
    assign latch_o = latch_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
